// File: rtl/wb_pkg.sv
// Shared constants and types for the writeback stage: result-source codes,
// load funct3 encodings and the stage FSM state type.
package wb_pkg;

  localparam logic [1:0] RES_ALU  = 2'b00;
  localparam logic [1:0] RES_LOAD = 2'b01;
  localparam logic [1:0] RES_PC4  = 2'b10;
  localparam logic [1:0] RES_IMM  = 2'b11;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;

  typedef enum logic [0:0] {IDLE, WAIT_LOAD} wb_state_t;

endpackage

// File: rtl/load_extend.sv
// Combinational lane select and sign/zero extension of an aligned load word.
module load_extend
  import wb_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN-1:0]              rdata_i,
  input  logic [$clog2(XLEN/8)-1:0]    offset_i,
  input  logic [2:0]                   funct3_i,
  output logic [XLEN-1:0]              ext_o
);

  localparam int unsigned OW = $clog2(XLEN/8);

  logic [7:0]      lane_b;
  logic [15:0]     lane_h;
  logic [XLEN-1:0] lw_val, lwu_val, ld_val;

  assign lane_b = rdata_i[{offset_i, 3'b000} +: 8];
  // Halfword lane ignores the low offset bit.
  assign lane_h = rdata_i[{offset_i[OW-1:1], 4'b0000} +: 16];

  if (XLEN == 64) begin : g_x64
    logic [31:0] lane_w;
    assign lane_w  = offset_i[OW-1] ? rdata_i[63:32] : rdata_i[31:0];
    assign lw_val  = {{32{lane_w[31]}}, lane_w};
    assign lwu_val = {32'b0, lane_w};
    assign ld_val  = rdata_i;
  end else begin : g_x32
    assign lw_val  = rdata_i;
    assign lwu_val = '0;
    assign ld_val  = '0;
  end

  always_comb begin
    ext_o = '0;
    case (funct3_i)
      F3_LB:   ext_o = {{(XLEN-8){lane_b[7]}}, lane_b};
      F3_LBU:  ext_o = {{(XLEN-8){1'b0}}, lane_b};
      F3_LH:   ext_o = {{(XLEN-16){lane_h[15]}}, lane_h};
      F3_LHU:  ext_o = {{(XLEN-16){1'b0}}, lane_h};
      F3_LW:   ext_o = lw_val;
      F3_LWU:  ext_o = lwu_val;
      F3_LD:   ext_o = ld_val;
      default: ext_o = '0;
    endcase
  end

endmodule

// File: rtl/wb_stage_ext.sv
// Writeback stage: result select, load extension, late-load wait with
// backpressure, and a registered single-cycle writeback beat.
module wb_stage_ext
  import wb_pkg::*;
#(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned REG_AW = 5
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              regwrite_w,
  input  logic [1:0]        result_src_w,
  input  logic [2:0]        funct3_w,
  input  logic [XLEN-1:0]   alu_result_w,
  input  logic [XLEN-1:0]   pc_plus_4_w,
  input  logic [XLEN-1:0]   imm_w,
  input  logic [REG_AW-1:0] rd_w,
  input  logic              mem_rvalid,
  input  logic [XLEN-1:0]   mem_rdata,
  output logic              wb_valid,
  output logic              wb_regwrite,
  output logic [REG_AW-1:0] wb_rd,
  output logic [XLEN-1:0]   wb_result,
  output logic              busy
);

  localparam int unsigned OW = $clog2(XLEN/8);

  wb_state_t         state_q, state_d;
  logic [REG_AW-1:0] cap_rd_q, cap_rd_d;
  logic              cap_regwrite_q, cap_regwrite_d;
  logic [2:0]        cap_funct3_q, cap_funct3_d;
  logic [OW-1:0]     cap_off_q, cap_off_d;
  logic              wb_valid_q, wb_valid_d;
  logic              wb_regwrite_q, wb_regwrite_d;
  logic [REG_AW-1:0] wb_rd_q, wb_rd_d;
  logic [XLEN-1:0]   wb_result_q, wb_result_d;

  logic [OW-1:0]     ext_off;
  logic [2:0]        ext_funct3;
  logic [XLEN-1:0]   ext_val;
  logic [XLEN-1:0]   sel_val;

  // Lane select follows the captured fields while a load is outstanding.
  assign ext_off    = (state_q == WAIT_LOAD) ? cap_off_q : alu_result_w[OW-1:0];
  assign ext_funct3 = (state_q == WAIT_LOAD) ? cap_funct3_q : funct3_w;

  load_extend #(
    .XLEN(XLEN)
  ) u_load_extend (
    .rdata_i (mem_rdata),
    .offset_i(ext_off),
    .funct3_i(ext_funct3),
    .ext_o   (ext_val)
  );

  always_comb begin
    case (result_src_w)
      RES_ALU:  sel_val = alu_result_w;
      RES_LOAD: sel_val = ext_val;
      RES_PC4:  sel_val = pc_plus_4_w;
      default:  sel_val = imm_w;
    endcase
  end

  always_comb begin
    state_d        = state_q;
    cap_rd_d       = cap_rd_q;
    cap_regwrite_d = cap_regwrite_q;
    cap_funct3_d   = cap_funct3_q;
    cap_off_d      = cap_off_q;
    wb_valid_d     = 1'b0;
    wb_regwrite_d  = 1'b0;
    wb_rd_d        = wb_rd_q;
    wb_result_d    = wb_result_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (result_src_w != RES_LOAD || mem_rvalid) begin
            wb_valid_d    = 1'b1;
            wb_rd_d       = rd_w;
            wb_regwrite_d = regwrite_w && (rd_w != '0);
            wb_result_d   = sel_val;
          end else begin
            cap_rd_d       = rd_w;
            cap_regwrite_d = regwrite_w;
            cap_funct3_d   = funct3_w;
            cap_off_d      = alu_result_w[OW-1:0];
            state_d        = WAIT_LOAD;
          end
        end
      end
      WAIT_LOAD: begin
        if (mem_rvalid) begin
          wb_valid_d    = 1'b1;
          wb_rd_d       = cap_rd_q;
          wb_regwrite_d = cap_regwrite_q && (cap_rd_q != '0);
          wb_result_d   = ext_val;
          state_d       = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= IDLE;
      cap_rd_q       <= '0;
      cap_regwrite_q <= 1'b0;
      cap_funct3_q   <= '0;
      cap_off_q      <= '0;
      wb_valid_q     <= 1'b0;
      wb_regwrite_q  <= 1'b0;
      wb_rd_q        <= '0;
      wb_result_q    <= '0;
    end else begin
      state_q        <= state_d;
      cap_rd_q       <= cap_rd_d;
      cap_regwrite_q <= cap_regwrite_d;
      cap_funct3_q   <= cap_funct3_d;
      cap_off_q      <= cap_off_d;
      wb_valid_q     <= wb_valid_d;
      wb_regwrite_q  <= wb_regwrite_d;
      wb_rd_q        <= wb_rd_d;
      wb_result_q    <= wb_result_d;
    end
  end

  assign in_ready    = (state_q == IDLE);
  assign busy        = (state_q == WAIT_LOAD);
  assign wb_valid    = wb_valid_q;
  assign wb_regwrite = wb_regwrite_q;
  assign wb_rd       = wb_rd_q;
  assign wb_result   = wb_result_q;

endmodule

// File: tb/tb_wb_stage_ext.sv
// Bench for wb_stage_ext: XLEN=32 and XLEN=64 instances, vector table plus
// hand-written late-load and reset sequences, scoreboard on writeback beats.
module tb_wb_stage_ext;

  typedef struct {
    logic        is64;
    logic [1:0]  src;
    logic [2:0]  f3;
    logic [63:0] alu;
    logic [63:0] pc4;
    logic [63:0] imm;
    logic [63:0] rdata;
    logic [4:0]  rd;
    logic        rw;
    logic [63:0] exp_res;
    logic        exp_rw;
  } vec_t;

  typedef struct {
    logic [4:0]  rd;
    logic        rw;
    logic [63:0] res;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  exp_t q32[$];
  exp_t q64[$];

  logic        in_valid32 = 1'b0, in_ready32, regwrite32 = 1'b0, mem_rvalid32 = 1'b0;
  logic [1:0]  src32 = '0;
  logic [2:0]  f3_32 = '0;
  logic [31:0] alu32 = '0, pc4_32 = '0, imm32 = '0, rdata32 = '0, wb_result32;
  logic [4:0]  rd32 = '0, wb_rd32;
  logic        wb_valid32, wb_regwrite32, busy32;

  logic        in_valid64 = 1'b0, in_ready64, regwrite64 = 1'b0, mem_rvalid64 = 1'b0;
  logic [1:0]  src64 = '0;
  logic [2:0]  f3_64 = '0;
  logic [63:0] alu64 = '0, pc4_64 = '0, imm64 = '0, rdata64 = '0, wb_result64;
  logic [4:0]  rd64 = '0, wb_rd64;
  logic        wb_valid64, wb_regwrite64, busy64;

  wb_stage_ext #(.XLEN(32), .REG_AW(5)) dut32 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid32), .in_ready(in_ready32),
    .regwrite_w(regwrite32), .result_src_w(src32), .funct3_w(f3_32),
    .alu_result_w(alu32), .pc_plus_4_w(pc4_32), .imm_w(imm32), .rd_w(rd32),
    .mem_rvalid(mem_rvalid32), .mem_rdata(rdata32), .wb_valid(wb_valid32),
    .wb_regwrite(wb_regwrite32), .wb_rd(wb_rd32), .wb_result(wb_result32), .busy(busy32)
  );

  wb_stage_ext #(.XLEN(64), .REG_AW(5)) dut64 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid64), .in_ready(in_ready64),
    .regwrite_w(regwrite64), .result_src_w(src64), .funct3_w(f3_64),
    .alu_result_w(alu64), .pc_plus_4_w(pc4_64), .imm_w(imm64), .rd_w(rd64),
    .mem_rvalid(mem_rvalid64), .mem_rdata(rdata64), .wb_valid(wb_valid64),
    .wb_regwrite(wb_regwrite64), .wb_rd(wb_rd64), .wb_result(wb_result64), .busy(busy64)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset_n) begin
      if (wb_valid32) begin
        if (q32.size() == 0) begin
          chk("wb32_unexpected_valid", 64'(wb_valid32), 64'd0);
        end else begin
          exp_t e;
          e = q32.pop_front();
          chk("wb32_rd", 64'(wb_rd32), 64'(e.rd));
          chk("wb32_regwrite", 64'(wb_regwrite32), 64'(e.rw));
          chk("wb32_result", {32'b0, wb_result32}, e.res);
          chk("wb32_cycle", 64'(cyc), 64'(e.cyc));
        end
      end else begin
        chk("wb32_idle_regwrite", 64'(wb_regwrite32), 64'd0);
      end
      if (wb_valid64) begin
        if (q64.size() == 0) begin
          chk("wb64_unexpected_valid", 64'(wb_valid64), 64'd0);
        end else begin
          exp_t e;
          e = q64.pop_front();
          chk("wb64_rd", 64'(wb_rd64), 64'(e.rd));
          chk("wb64_regwrite", 64'(wb_regwrite64), 64'(e.rw));
          chk("wb64_result", wb_result64, e.res);
          chk("wb64_cycle", 64'(cyc), 64'(e.cyc));
        end
      end else begin
        chk("wb64_idle_regwrite", 64'(wb_regwrite64), 64'd0);
      end
    end
  end

  function automatic vec_t mk(input logic is64, input logic [1:0] src, input logic [2:0] f3,
                              input logic [63:0] alu, input logic [63:0] pc4,
                              input logic [63:0] imm, input logic [63:0] rdata,
                              input logic [4:0] rd, input logic rw,
                              input logic [63:0] exp_res, input logic exp_rw);
    vec_t v;
    v.is64 = is64; v.src = src; v.f3 = f3; v.alu = alu; v.pc4 = pc4; v.imm = imm;
    v.rdata = rdata; v.rd = rd; v.rw = rw; v.exp_res = exp_res; v.exp_rw = exp_rw;
    return v;
  endfunction

  // Drives one same-cycle operation (loads carry mem_rvalid=1) and queues its result.
  task automatic drive(input vec_t v);
    exp_t e;
    e.rd = v.rd; e.rw = v.exp_rw; e.res = v.exp_res; e.cyc = cyc + 1;
    in_valid32 = 1'b0;
    in_valid64 = 1'b0;
    mem_rvalid32 = 1'b0;
    mem_rvalid64 = 1'b0;
    if (!v.is64) begin
      in_valid32 = 1'b1; src32 = v.src; f3_32 = v.f3; alu32 = v.alu[31:0];
      pc4_32 = v.pc4[31:0]; imm32 = v.imm[31:0]; rdata32 = v.rdata[31:0];
      rd32 = v.rd; regwrite32 = v.rw; mem_rvalid32 = 1'b1;
      q32.push_back(e);
    end else begin
      in_valid64 = 1'b1; src64 = v.src; f3_64 = v.f3; alu64 = v.alu;
      pc4_64 = v.pc4; imm64 = v.imm; rdata64 = v.rdata;
      rd64 = v.rd; regwrite64 = v.rw; mem_rvalid64 = 1'b1;
      q64.push_back(e);
    end
  endtask

  vec_t tbl[22];

  initial begin
    exp_t e;
    tbl[0]  = mk(0, 2'b00, 3'b000, 64'h1234, 0, 0, 0, 5'd5, 1, 64'h1234, 1);
    tbl[1]  = mk(0, 2'b01, 3'b000, 64'h1003, 0, 0, 64'h80FF7F01, 5'd1, 1, 64'hFFFFFF80, 1);
    tbl[2]  = mk(0, 2'b01, 3'b100, 64'h1002, 0, 0, 64'h80FF7F01, 5'd2, 1, 64'h000000FF, 1);
    tbl[3]  = mk(0, 2'b01, 3'b001, 64'h1002, 0, 0, 64'h80FF7F01, 5'd3, 1, 64'hFFFF80FF, 1);
    tbl[4]  = mk(0, 2'b01, 3'b101, 64'h1000, 0, 0, 64'h80FF7F01, 5'd4, 1, 64'h00007F01, 1);
    tbl[5]  = mk(0, 2'b01, 3'b000, 64'h1000, 0, 0, 64'h80FF7F01, 5'd6, 1, 64'h00000001, 1);
    tbl[6]  = mk(0, 2'b01, 3'b100, 64'h1003, 0, 0, 64'h80FF7F01, 5'd7, 1, 64'h00000080, 1);
    tbl[7]  = mk(0, 2'b01, 3'b100, 64'h1001, 0, 0, 64'h80FF7F01, 5'd8, 1, 64'h0000007F, 1);
    tbl[8]  = mk(0, 2'b01, 3'b001, 64'h1003, 0, 0, 64'h80FF7F01, 5'd9, 1, 64'hFFFF80FF, 1);
    tbl[9]  = mk(0, 2'b01, 3'b010, 64'h1000, 0, 0, 64'h80FF7F01, 5'd10, 1, 64'h80FF7F01, 1);
    tbl[10] = mk(0, 2'b01, 3'b110, 64'h1000, 0, 0, 64'h80FF7F01, 5'd11, 1, 64'h0, 1);
    tbl[11] = mk(0, 2'b01, 3'b011, 64'h1000, 0, 0, 64'h80FF7F01, 5'd12, 1, 64'h0, 1);
    tbl[12] = mk(0, 2'b01, 3'b111, 64'h1000, 0, 0, 64'h80FF7F01, 5'd13, 1, 64'h0, 1);
    tbl[13] = mk(0, 2'b10, 3'b000, 0, 64'h100, 0, 0, 5'd0, 1, 64'h100, 0);
    tbl[14] = mk(0, 2'b11, 3'b000, 0, 0, 64'hABCDE000, 0, 5'd14, 0, 64'hABCDE000, 0);
    tbl[15] = mk(1, 2'b01, 3'b110, 64'h2004, 0, 0, 64'hFFFFFFFF_00000000, 5'd1, 1,
                 64'h00000000_FFFFFFFF, 1);
    tbl[16] = mk(1, 2'b01, 3'b010, 64'h2004, 0, 0, 64'hFFFFFFFF_00000000, 5'd2, 1,
                 64'hFFFFFFFF_FFFFFFFF, 1);
    tbl[17] = mk(1, 2'b01, 3'b010, 64'h2000, 0, 0, 64'hFFFFFFFF_00000000, 5'd3, 1, 64'h0, 1);
    tbl[18] = mk(1, 2'b01, 3'b011, 64'h2000, 0, 0, 64'h01234567_89ABCDEF, 5'd4, 1,
                 64'h01234567_89ABCDEF, 1);
    tbl[19] = mk(1, 2'b01, 3'b101, 64'h2006, 0, 0, 64'h01234567_89ABCDEF, 5'd5, 1,
                 64'h0000_0000_0000_0123, 1);
    tbl[20] = mk(1, 2'b01, 3'b000, 64'h2001, 0, 0, 64'h01234567_89ABCDEF, 5'd6, 1,
                 64'hFFFFFFFF_FFFFFFCD, 1);
    tbl[21] = mk(1, 2'b00, 3'b000, 64'hFEDCBA98_76543210, 0, 0, 0, 5'd31, 1,
                 64'hFEDCBA98_76543210, 1);

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_wb_valid", 64'(wb_valid32), 0);
    chk("rst_wb_regwrite", 64'(wb_regwrite32), 0);
    chk("rst_wb_rd", 64'(wb_rd32), 0);
    chk("rst_wb_result", 64'(wb_result32), 0);
    chk("rst_busy", 64'(busy32), 0);
    chk("rst_wb64_result", wb_result64, 0);
    reset_n = 1'b1;
    #1;
    chk("rel_in_ready", 64'(in_ready32), 1);

    // Back-to-back table vectors.
    for (int i = 0; i < 22; i++) begin
      @(posedge clk); #1;
      drive(tbl[i]);
    end
    @(posedge clk); #1;
    in_valid32 = 1'b0; in_valid64 = 1'b0; mem_rvalid32 = 1'b0; mem_rvalid64 = 1'b0;
    repeat (2) @(posedge clk);

    // Late load with a second operation held behind it.
    @(posedge clk); #1;
    in_valid32 = 1'b1; src32 = 2'b01; f3_32 = 3'b010; alu32 = 32'h3000;
    rd32 = 5'd7; regwrite32 = 1'b1; mem_rvalid32 = 1'b0; rdata32 = 32'h0;
    @(posedge clk); #1;
    chk("late_in_ready", 64'(in_ready32), 0);
    chk("late_busy", 64'(busy32), 1);
    src32 = 2'b00; f3_32 = 3'b000; alu32 = 32'h55; rd32 = 5'd3; regwrite32 = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      chk("late_hold_wb_valid", 64'(wb_valid32), 0);
      chk("late_hold_in_ready", 64'(in_ready32), 0);
    end
    mem_rvalid32 = 1'b1; rdata32 = 32'hDEADBEEF;
    chk("late_rvalid_in_ready", 64'(in_ready32), 0);
    e.rd = 5'd7; e.rw = 1'b1; e.res = 64'hDEADBEEF; e.cyc = cyc + 1;
    q32.push_back(e);
    e.rd = 5'd3; e.rw = 1'b1; e.res = 64'h55; e.cyc = cyc + 2;
    q32.push_back(e);
    @(posedge clk); #1;
    mem_rvalid32 = 1'b0; rdata32 = 32'h0;
    chk("late_after_in_ready", 64'(in_ready32), 1);
    chk("late_after_busy", 64'(busy32), 0);
    @(posedge clk); #1;
    in_valid32 = 1'b0;
    repeat (2) @(posedge clk);

    // Reset while waiting for a load.
    @(posedge clk); #1;
    in_valid32 = 1'b1; src32 = 2'b01; f3_32 = 3'b010; alu32 = 32'h4000;
    rd32 = 5'd9; regwrite32 = 1'b1; mem_rvalid32 = 1'b0;
    @(posedge clk); #1;
    in_valid32 = 1'b0;
    chk("midrst_busy_before", 64'(busy32), 1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("midrst_wb_valid", 64'(wb_valid32), 0);
    chk("midrst_wb_regwrite", 64'(wb_regwrite32), 0);
    chk("midrst_wb_rd", 64'(wb_rd32), 0);
    chk("midrst_wb_result", 64'(wb_result32), 0);
    chk("midrst_busy", 64'(busy32), 0);
    @(posedge clk); #3;
    reset_n = 1'b1;
    #1;
    chk("midrst_in_ready", 64'(in_ready32), 1);
    @(posedge clk); #1;
    mem_rvalid32 = 1'b1; rdata32 = 32'h12345678;
    repeat (2) begin
      @(posedge clk); #1;
      chk("stray_rvalid_wb_valid", 64'(wb_valid32), 0);
    end
    mem_rvalid32 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("q32_drained", 64'(q32.size()), 0);
    chk("q64_drained", 64'(q64.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
